// File: rtl/xsleena_gfx_sdr_arbiter.sv
// Round-robin arbiter sharing one SDRAM ROM read port
// between the graphics-layer fetchers (clk_ram domain).
module xsleena_gfx_sdr_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 25,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_ram,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  output logic [NREQ-1:0]      rdy_o,
  output logic [NREQ*16-1:0]   data_o,
  output logic [AW-1:0]        sdr_addr,
  output logic                 sdr_req,
  input  logic                 sdr_rdy,
  input  logic [15:0]          sdr_data,
  output logic                 timeout_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 10;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     pend_q, pend_d;
  logic [AW-1:0]       addr_q [NREQ];
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       saddr_q, saddr_d;
  logic                sreq_q, sreq_d;
  logic [NREQ-1:0]     rdy_q, rdy_d;
  logic [NREQ*16-1:0]  data_q, data_d;
  logic                to_q, to_d;

  logic                found;
  logic [IW-1:0]       gsel;

  // First pending requester after the last one served, wrapping.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gsel  = IW'(idx);
      end
    end
  end

  // Next-state and output logic: grant in IDLE, await data in WAIT.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    saddr_d = saddr_q;
    sreq_d  = 1'b0;
    rdy_d   = '0;
    data_d  = data_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          rr_d         = gsel;
          gnt_d        = gsel;
          pend_d[gsel] = 1'b0;
          saddr_d      = addr_q[gsel];
          sreq_d       = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (sdr_rdy) begin
          data_d[int'(gnt_q)*16 +: 16] = sdr_data;
          rdy_d[gnt_q] = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    // A request in the grant cycle re-arms the flag; the grant
    // already used the previously stored address.
    pend_d = pend_d | req_i;
  end

  // State, flags and registered outputs.
  always_ff @(posedge clk_ram) begin
    if (RESET) begin
      state_q <= IDLE;
      pend_q  <= '0;
      rr_q    <= IW'(NREQ - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
      saddr_q <= '0;
      sreq_q  <= 1'b0;
      rdy_q   <= '0;
      data_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      saddr_q <= saddr_d;
      sreq_q  <= sreq_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      to_q    <= to_d;
    end
  end

  // Per-requester address capture; latest request wins.
  always_ff @(posedge clk_ram) begin
    for (int i = 0; i < NREQ; i++) begin
      if (RESET) begin
        addr_q[i] <= '0;
      end else if (req_i[i]) begin
        addr_q[i] <= req_addr_i[i*AW +: AW];
      end
    end
  end

  assign rdy_o     = rdy_q;
  assign data_o    = data_q;
  assign sdr_addr  = saddr_q;
  assign sdr_req   = sreq_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_xsleena_gfx_sdr_arbiter.sv
// Scoreboard bench for the SDRAM ROM arbiter:
// reference model predicts events, monitor checks them.
module tb_xsleena_gfx_sdr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 25;
  localparam int TO   = 8;

  logic               clk = 1'b0;
  logic               RESET;
  logic [NREQ-1:0]    req_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ-1:0]    rdy_o;
  logic [NREQ*16-1:0] data_o;
  logic [AW-1:0]      sdr_addr;
  logic               sdr_req;
  logic               sdr_rdy;
  logic [15:0]        sdr_data;
  logic               timeout_o;

  xsleena_gfx_sdr_arbiter #(
    .NREQ(NREQ), .AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk_ram(clk), .RESET(RESET),
    .req_i(req_i), .req_addr_i(req_addr_i),
    .rdy_o(rdy_o), .data_o(data_o),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req),
    .sdr_rdy(sdr_rdy), .sdr_data(sdr_data),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk  = 0;
  int npass = 0;

  typedef struct {
    int          c;
    int          idx;
    logic [31:0] v;
  } ev_t;

  ev_t qs[$];
  ev_t qr[$];
  ev_t qt[$];

  // reference model: transaction-level view of the arbiter
  bit          m_pend [NREQ];
  logic [AW-1:0] m_addr [NREQ];
  logic [15:0] m_data [NREQ];
  logic [AW-1:0] m_saddr;
  int          m_rr;
  bit          m_busy;
  int          m_g;
  int          m_issue;
  int          m_lat;
  bit          mon_en = 0;

  // controller behaviour
  bit ctl_on   = 1;
  bit ctl_rand = 0;
  int fix_lat  = 3;

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h",
                  nm, cyc, a, e);
  endtask

  task automatic model(input logic rst,
                       input logic [NREQ-1:0] rq,
                       input logic [NREQ*AW-1:0] ad,
                       input logic r,
                       input logic [15:0] d,
                       input int k);
    ev_t ev;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        m_pend[i] = 0;
        m_data[i] = '0;
      end
      m_saddr = '0;
      m_rr    = NREQ - 1;
      m_busy  = 0;
      return;
    end
    if (m_busy) begin
      if (r) begin
        ev.c = k + 1; ev.idx = m_g; ev.v = 32'(d);
        qr.push_back(ev);
        m_data[m_g] = d;
        m_busy = 0;
      end else if (k + 1 - m_issue == TO) begin
        ev.c = k + 1; ev.idx = 0; ev.v = 0;
        qt.push_back(ev);
        m_busy = 0;
      end
    end else begin
      for (int j = 1; j <= NREQ; j++) begin
        int idx;
        idx = (m_rr + j) % NREQ;
        if (!m_busy && m_pend[idx]) begin
          ev.c = k + 1; ev.idx = idx; ev.v = 32'(m_addr[idx]);
          qs.push_back(ev);
          m_saddr   = m_addr[idx];
          m_busy    = 1;
          m_issue   = k + 1;
          m_g       = idx;
          m_rr      = idx;
          m_pend[idx] = 0;
          m_lat = ctl_rand ? int'($urandom_range(0, TO + 1))
                           : fix_lat;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i]) begin
        m_pend[i] = 1;
        m_addr[i] = ad[i*AW +: AW];
      end
    end
  endtask

  task automatic step(input logic rst,
                      input logic [NREQ-1:0] rq,
                      input logic [NREQ*AW-1:0] ad,
                      input logic spur);
    logic        r;
    logic [15:0] d;
    int          k;
    k = cyc;
    r = 1'b0;
    d = 16'($urandom);
    if (m_busy && ctl_on && k == m_issue + m_lat) r = 1'b1;
    if (!m_busy && spur) begin
      r = 1'b1;
      d = 16'hFFFF;
    end
    RESET      = rst;
    req_i      = rq;
    req_addr_i = ad;
    sdr_rdy    = r;
    sdr_data   = d;
    model(rst, rq, ad, r, d, k);
    mon_en = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [NREQ*AW-1:0] rand_ad();
    logic [NREQ*AW-1:0] a;
    logic [AW-1:0]      t;
    a = '0;
    for (int i = 0; i < NREQ; i++) begin
      t = AW'($urandom);
      a[i*AW +: AW] = t;
    end
    return a;
  endfunction

  // monitor: compare DUT outputs against predicted events
  initial begin
    logic [NREQ*16-1:0] ed;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (qs.size() > 0 && qs[0].c == cyc) begin
          chk("sdr_req", 64'(sdr_req), 64'd1);
          chk("sdr_addr_grant", 64'(sdr_addr), 64'(qs[0].v));
          void'(qs.pop_front());
        end else begin
          chk("sdr_req_quiet", 64'(sdr_req), 64'd0);
        end
        if (qr.size() > 0 && qr[0].c == cyc) begin
          chk("rdy_o", 64'(rdy_o), 64'(1 << qr[0].idx));
          chk("data_ret",
              64'(data_o[qr[0].idx*16 +: 16]), 64'(qr[0].v));
          void'(qr.pop_front());
        end else begin
          chk("rdy_o_quiet", 64'(rdy_o), 64'd0);
        end
        if (qt.size() > 0 && qt[0].c == cyc) begin
          chk("timeout_o", 64'(timeout_o), 64'd1);
          void'(qt.pop_front());
        end else begin
          chk("timeout_quiet", 64'(timeout_o), 64'd0);
        end
        for (int i = 0; i < NREQ; i++) ed[i*16 +: 16] = m_data[i];
        chk("data_o_held", 64'(data_o), 64'(ed));
        chk("sdr_addr_held", 64'(sdr_addr), 64'(m_saddr));
      end
    end
  end

  // stimulus
  initial begin
    logic [NREQ*AW-1:0] ad;
    RESET      = 1'b1;
    req_i      = '0;
    req_addr_i = '0;
    sdr_rdy    = 1'b0;
    sdr_data   = '0;
    @(negedge clk);
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    idle(2);

    // single request, controller answers 4 cycles after sdr_req
    fix_lat = 4;
    ad = '0;
    ad[1*AW +: AW] = 25'h0123456;
    step(1'b0, 3'b010, ad, 1'b0);
    idle(10);

    // round-robin bursts
    fix_lat = 3;
    step(1'b0, 3'b111, rand_ad(), 1'b0);
    idle(25);
    step(1'b0, 3'b111, rand_ad(), 1'b0);
    idle(25);

    // overwrite while pending, then a pulse in the grant cycle
    ad = rand_ad();
    step(1'b0, 3'b010, ad, 1'b0);
    ad = '0; ad[AW-1:0] = 25'h100;
    step(1'b0, 3'b001, ad, 1'b0);
    ad = '0; ad[AW-1:0] = 25'h200;
    step(1'b0, 3'b001, ad, 1'b0);
    idle(3);
    ad = '0; ad[AW-1:0] = 25'h300;
    step(1'b0, 3'b001, ad, 1'b0);
    idle(20);

    // timeout with a second request pending
    ctl_on = 0;
    step(1'b0, 3'b011, rand_ad(), 1'b0);
    idle(30);

    // reset during WAIT, then a late sdr_rdy
    step(1'b0, 3'b101, rand_ad(), 1'b0);
    idle(2);
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    idle(5);
    ctl_on = 1;

    // spurious sdr_rdy while idle
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    idle(3);

    // randomized traffic
    ctl_rand = 1;
    repeat (3000) begin
      logic rst;
      logic sp;
      rst = ($urandom % 200) == 0;
      sp  = ($urandom % 10) == 0;
      step(rst, NREQ'($urandom & $urandom), rand_ad(), sp);
    end
    idle(TO + 20);

    chk("queues_drained",
        64'(qs.size() + qr.size() + qt.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/xsleena_gfx_sdr_arbiter.md
Name: xsleena_gfx_sdr_arbiter

Overview:
- Shares one SDRAM ROM read port between the graphics-layer fetchers: BACK1, BACK2 and the sprite/text ROM fetchers.
- Each fetcher raises a one-cycle request carrying a word address. The arbiter queues requests per requester, grants them round-robin, issues one request at a time to the SDRAM controller and returns the 16-bit word with a one-cycle ready pulse.
- Sits between the layer blocks' sdr_addr/sdr_req/sdr_rdy/sdr_data interfaces and the SDRAM controller ROM channel, in the clk_ram domain.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 25, SDRAM address width.
- TIMEOUT, 255, clk_ram cycles to wait for sdr_rdy before abandoning a transfer (1..1023).

Ports:
- clk_ram  in  1  SDRAM-domain clock; everything is synchronous to its rising edge.
- RESET  in  1  synchronous reset, active-high.
- req_i  in  NREQ  per-requester request pulse (bit i = requester i).
- req_addr_i  in  NREQ*AW  packed addresses; slice i is [i*AW +: AW], sampled when req_i[i]=1.
- rdy_o  out  NREQ  one-cycle ready pulse per requester.
- data_o  out  NREQ*16  packed per-requester returned word; held until that requester's next completion.
- sdr_addr  out  AW  address to the SDRAM controller.
- sdr_req  out  1  one-cycle request pulse to the SDRAM controller.
- sdr_rdy  in  1  one-cycle data-valid from the SDRAM controller.
- sdr_data  in  16  read data, valid with sdr_rdy.
- timeout_o  out  1  one-cycle pulse when a transfer is abandoned.

Behaviour:
- Reset values (takes effect the cycle after RESET is sampled high):
  - state=IDLE; all pending flags=0; rr pointer=NREQ-1.
  - sdr_req=0, sdr_addr=0, rdy_o=0, data_o=0, timeout_o=0.
  - A reset during WAIT abandons the transfer with no rdy_o and no timeout_o. A sdr_rdy arriving later in IDLE is ignored.
- Request capture:
  - req_i[i]=1 in cycle N sets pending[i] and stores the address in addr_q[i] at the end of N.
  - A new req_i[i] while pending[i]=1 overwrites addr_q[i] (latest wins); it is not queued twice.
- Arbitration in IDLE when any pending=1:
  - Grant the first pending index searching from rr+1 upward, wrapping at NREQ.
  - rr := granted index; clear pending[g]; sdr_addr := addr_q[g]; sdr_req := 1; go to WAIT.
  - sdr_req is high for exactly one cycle (cycle N+2 for a request made in cycle N from an idle arbiter).
- Simultaneous request and grant: if req_i[g] arrives in the same cycle that g is granted, the grant uses the old addr_q[g]. pending[g] stays 1 and addr_q[g] takes the new address.
- WAIT state:
  - A cycle counter runs from 0. sdr_rdy=1 in cycle M captures sdr_data into data_o slice g.
  - rdy_o[g]=1 in M+1, data valid from M+1. State returns to IDLE in M+1, so the next sdr_req can come no earlier than M+2.
  - If the counter reaches TIMEOUT without sdr_rdy: timeout_o pulses one cycle, go to IDLE, no rdy_o, data_o unchanged.
- sdr_rdy in IDLE is ignored.
- Only one outstanding SDRAM transfer at any time; sdr_req is never asserted while in WAIT.
- rdy_o is one-hot or zero in every cycle.

Test Plan:
- Single request: req_i=3'b010, addr 0x0123456 at cycle 0; sdr_rdy with 0xBEEF at cycle 6 -> sdr_req=1 only in cycle 2 with sdr_addr=0x0123456; rdy_o=3'b010 at cycle 7; data_o slice1=0xBEEF and held.
- Round-robin: all three requesters pulse in cycle 0; controller answers 3 cycles after each sdr_req -> grant order 0,1,2. Repeating the burst after the last grant was 2 gives order 0,1,2 again. Starting with rr=0 gives order 1,2,0.
- Overwrite/coincidence: requester 0 pulses 0x100, then 0x200 before it is granted -> exactly one sdr_req with 0x200. A pulse of 0x300 in the grant cycle -> that grant uses 0x200 and a second sdr_req follows with 0x300.
- Timeout: TIMEOUT=8, sdr_rdy never asserted -> timeout_o pulse 8 cycles after sdr_req; no rdy_o; the next pending request is issued afterwards.
- Reset mid-WAIT: RESET high for 1 cycle after sdr_req, then a late sdr_rdy -> no rdy_o; all outputs 0; pending cleared.
- Spurious sdr_rdy in IDLE with 0xFFFF -> no rdy_o and data_o unchanged.
